game_flow_controller: RTL and testbench
=======================================

Name: game_flow_controller

Overview:
- Game-flow sequencer that drives the top-level display/game logic.
- Generates the motion strobes for the game: `upsig` for the player and obstacles, `upsig_fast` for the background scroll, and `drop` for obstacle spawns.
- Consumes the collision flag from the collision manager to run the crash, lives and game-over sequence.
- Also produces the distance score shown on the scoreboard.

Parameters:
- SLOW_DIV, 500000, clk cycles per `upsig` period (≥2).
- FAST_DIV, 250000, clk cycles per `upsig_fast` period (≥2).
- DROP_PERIOD, 64, number of `upsig` pulses per `drop` pulse (≥1).
- CRASH_TICKS, 100, number of slow-tick periods the game stays frozen after a crash (≥1).
- LIVES, 3, initial lives (1..3).

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  start button, level, synchronous to clk.
- colision  in  1  collision flag from the collision manager, level.
- upsig  out  1  one-clk slow motion strobe.
- upsig_fast  out  1  one-clk fast scroll strobe.
- drop  out  1  one-clk obstacle spawn strobe.
- running  out  1  high in RUN.
- crash  out  1  high in CRASH.
- game_over  out  1  high in OVER.
- lives  out  2  remaining lives.
- distance  out  16  score, counted in slow ticks.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE.
  - All strobes 0; `running`/`crash`/`game_over` 0.
  - `lives`=LIVES, `distance`=0.
  - Prescalers, drop counter and crash counter 0; start-edge register 0.
- Start edge: `start_rise` = `start` & ~`start_d`, with `start_d` registered every cycle.
- Prescalers:
  - `slow_cnt` runs 0..SLOW_DIV-1 and wraps; `slow_tick`=1 in the cycle `slow_cnt`==SLOW_DIV-1.
  - `fast_cnt` runs 0..FAST_DIV-1 and wraps; `fast_tick`=1 in the cycle `fast_cnt`==FAST_DIV-1.
  - Both count in RUN and CRASH.
  - Both are held at 0 in IDLE and OVER.
  - Both are cleared on any transition into RUN from IDLE or OVER.
  - Counter widths use $clog2.
- IDLE:
  - All strobes 0.
  - `start_rise` → RUN: `lives`=LIVES, `distance`=0, drop counter 0.
- RUN:
  - `running`=1.
  - `upsig` = `slow_tick`; `upsig_fast` = `fast_tick`; outputs are registered, so a strobe appears 1 cycle after the terminal count.
  - Each `upsig`: `distance`+1, saturating at 0xFFFF.
  - Each `upsig`: drop counter +1; when it reaches DROP_PERIOD, `drop`=1 coincident with that `upsig` and the counter resets to 0.
  - `colision`=1 in RUN → CRASH next cycle:
    - `lives` decrements (unless FREE_PLAY_EN); `crash_cnt`=0.
    - That cycle's strobes are suppressed even if a tick coincides (collision wins).
- CRASH:
  - `crash`=1.
  - `upsig`/`upsig_fast`/`drop` forced to 0; `distance` frozen; `colision` ignored.
  - `crash_cnt` +1 per `slow_tick`.
  - When `crash_cnt` reaches CRASH_TICKS:
    - → RUN if `lives`≠0, with prescalers continuing and not cleared.
    - → OVER if `lives`==0.
  - If `colision` is still high on re-entering RUN, it re-triggers CRASH (level semantics, intended).
- OVER:
  - `game_over`=1; all strobes 0.
  - `distance` and `lives` hold for display.
  - `start_rise` → RUN with a fresh game (`lives`=LIVES, `distance`=0).
- `start` is ignored in RUN and CRASH.
- Reset mid-operation returns to IDLE immediately and asynchronously with the reset values above; no strobe fires on reset release.
- `lives` never underflows: a decrement only happens from a nonzero value.

Optional Feature:
- FREE_PLAY_EN defined:
  - `lives` never decrements and stays at LIVES.
  - CRASH always returns to RUN; OVER is unreachable and `game_over` is constant 0.
- FREE_PLAY_EN undefined: lives/game-over behaviour exactly as above.

Test Plan:
All scenarios use SLOW_DIV=4, FAST_DIV=2, DROP_PERIOD=3, CRASH_TICKS=2, LIVES=2.
1. Reset low then high, `start` held 0 for 20 clk → state IDLE, no strobes, `lives`=2, `distance`=0.
2. Pulse `start` 1 clk → `running`=1; `upsig` every 4 clk; `upsig_fast` every 2 clk; `drop` on the 3rd, 6th, … `upsig`; `distance`=6 after 6 `upsig`.
3. Assert `colision` 1 clk in the same cycle as `slow_tick` → no `upsig` that cycle; `crash`=1, `lives`=1; no strobes for 2 slow periods; then `running`=1 and `distance` resumes from its frozen value.
4. Second collision → `lives`=0, CRASH for 2 slow periods, then `game_over`=1 with `distance` held; a `start` pulse then gives RUN with `lives`=2 and `distance`=0.
5. Force `distance` to 0xFFFE and let 3 `upsig` occur → `distance`=0xFFFF and stays there.
6. Assert reset low during CRASH → all outputs take reset values asynchronously, before the next clk edge; with FREE_PLAY_EN, repeat scenario 4 → `lives` stays at 2 and `game_over` is never asserted.

Source files
------------

// File: rtl/game_flow_controller.sv
// Game-flow sequencer: motion/scroll/spawn strobes, crash/lives/game-over FSM and distance score.
// Optional build macro FREE_PLAY_EN: lives never decrement, crashes always resume play.
module game_flow_controller #(
    parameter int SLOW_DIV    = 500000,
    parameter int FAST_DIV    = 250000,
    parameter int DROP_PERIOD = 64,
    parameter int CRASH_TICKS = 100,
    parameter int LIVES       = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        colision,
    output logic        upsig,
    output logic        upsig_fast,
    output logic        drop,
    output logic        running,
    output logic        crash,
    output logic        game_over,
    output logic [1:0]  lives,
    output logic [15:0] distance
);

    localparam int SLOW_W  = $clog2(SLOW_DIV);
    localparam int FAST_W  = $clog2(FAST_DIV);
    localparam int DROP_W  = $clog2(DROP_PERIOD + 1);
    localparam int CRASH_W = $clog2(CRASH_TICKS + 1);

    localparam logic [SLOW_W-1:0]  SLOW_LAST  = SLOW_W'(SLOW_DIV - 1);
    localparam logic [FAST_W-1:0]  FAST_LAST  = FAST_W'(FAST_DIV - 1);
    localparam logic [DROP_W-1:0]  DROP_LAST  = DROP_W'(DROP_PERIOD - 1);
    localparam logic [CRASH_W-1:0] CRASH_LAST = CRASH_W'(CRASH_TICKS - 1);
    localparam logic [1:0]         LIVES_INIT = 2'(LIVES);

    typedef enum logic [1:0] {IDLE, RUN, CRASH, OVER} state_t;

    state_t             state;
    logic               start_d;
    logic [SLOW_W-1:0]  slow_cnt;
    logic [FAST_W-1:0]  fast_cnt;
    logic [DROP_W-1:0]  drop_cnt;
    logic [CRASH_W-1:0] crash_cnt;

    logic active, slow_tick, fast_tick, start_rise;

    // Prescalers only run while a game is in progress (RUN or frozen CRASH).
    assign active     = (state == RUN) || (state == CRASH);
    assign slow_tick  = active && (slow_cnt == SLOW_LAST);
    assign fast_tick  = active && (fast_cnt == FAST_LAST);
    assign start_rise = start & ~start_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            start_d    <= 1'b0;
            slow_cnt   <= '0;
            fast_cnt   <= '0;
            drop_cnt   <= '0;
            crash_cnt  <= '0;
            upsig      <= 1'b0;
            upsig_fast <= 1'b0;
            drop       <= 1'b0;
            running    <= 1'b0;
            crash      <= 1'b0;
            game_over  <= 1'b0;
            lives      <= LIVES_INIT;
            distance   <= '0;
        end else begin
            start_d    <= start;
            upsig      <= 1'b0;
            upsig_fast <= 1'b0;
            drop       <= 1'b0;

            if (active) begin
                slow_cnt <= slow_tick ? '0 : slow_cnt + 1'b1;
                fast_cnt <= fast_tick ? '0 : fast_cnt + 1'b1;
            end else begin
                slow_cnt <= '0;
                fast_cnt <= '0;
            end

            case (state)
                IDLE, OVER: begin
                    if (start_rise) begin
                        state     <= RUN;
                        running   <= 1'b1;
                        game_over <= 1'b0;
                        lives     <= LIVES_INIT;
                        distance  <= '0;
                        drop_cnt  <= '0;
                    end
                end
                RUN: begin
                    // A collision wins over any tick landing in the same cycle.
                    if (colision) begin
                        state     <= CRASH;
                        running   <= 1'b0;
                        crash     <= 1'b1;
                        crash_cnt <= '0;
`ifndef FREE_PLAY_EN
                        if (lives != 2'd0) lives <= lives - 2'd1;
`endif
                    end else begin
                        upsig      <= slow_tick;
                        upsig_fast <= fast_tick;
                        if (slow_tick) begin
                            if (distance != 16'hFFFF) distance <= distance + 16'd1;
                            if (drop_cnt == DROP_LAST) begin
                                drop     <= 1'b1;
                                drop_cnt <= '0;
                            end else begin
                                drop_cnt <= drop_cnt + 1'b1;
                            end
                        end
                    end
                end
                CRASH: begin
                    if (slow_tick) begin
                        if (crash_cnt == CRASH_LAST) begin
                            crash     <= 1'b0;
                            crash_cnt <= '0;
`ifdef FREE_PLAY_EN
                            state     <= RUN;
                            running   <= 1'b1;
`else
                            if (lives != 2'd0) begin
                                state   <= RUN;
                                running <= 1'b1;
                            end else begin
                                state     <= OVER;
                                game_over <= 1'b1;
                                slow_cnt  <= '0;
                                fast_cnt  <= '0;
                            end
`endif
                        end else begin
                            crash_cnt <= crash_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed, table-driven bench for game_flow_controller with small prescaler settings.
module tb_game_flow_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        colision = 1'b0;
    logic        upsig, upsig_fast, drop, running, crash, game_over;
    logic [1:0]  lives;
    logic [15:0] distance;

`ifdef FREE_PLAY_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif
    localparam logic [1:0] L1 = FP ? 2'd2 : 2'd1;
    localparam logic [1:0] L0 = FP ? 2'd2 : 2'd0;

    game_flow_controller #(
        .SLOW_DIV(4), .FAST_DIV(2), .DROP_PERIOD(3), .CRASH_TICKS(2), .LIVES(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .colision(colision),
        .upsig(upsig), .upsig_fast(upsig_fast), .drop(drop),
        .running(running), .crash(crash), .game_over(game_over),
        .lives(lives), .distance(distance)
    );

    always #5 clk = ~clk;

    // flags: {running, crash, game_over, upsig, upsig_fast, drop}
    typedef struct {
        logic        st;
        logic        col;
        logic [5:0]  f;
        logic [1:0]  l;
        logic [15:0] d;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic s, input logic c, input logic [5:0] f,
                       input logic [1:0] l, input logic [15:0] d);
        vec_t v;
        v.st = s; v.col = c; v.f = f; v.l = l; v.d = d;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] outs();
        return {running, crash, game_over, upsig, upsig_fast, drop, lives, distance};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        // Row 1..4: start pulse, counters begin from zero
        add(1, 0, 6'b100_000, 2, 0);
        add(0, 0, 6'b100_000, 2, 0);
        add(0, 0, 6'b100_010, 2, 0);
        add(0, 0, 6'b100_000, 2, 0);
        // Rows 5..28: six slow periods, drop on every third upsig
        for (int k = 1; k <= 6; k++) begin
            add(0, 0, (k % 3 == 0) ? 6'b100_111 : 6'b100_110, 2, 16'(k));
            add(0, 0, 6'b100_000, 2, 16'(k));
            add(0, 0, 6'b100_010, 2, 16'(k));
            add(0, 0, 6'b100_000, 2, 16'(k));
        end
        // Row 29: collision on a slow tick, strobes suppressed
        add(0, 1, 6'b010_000, L1, 6);
        for (int i = 0; i < 7; i++) add(0, 0, 6'b010_000, L1, 6);
        // Row 37: back to RUN, distance resumes
        add(0, 0, 6'b100_000, L1, 6);
        add(0, 0, 6'b100_000, L1, 6);
        add(0, 0, 6'b100_010, L1, 6);
        add(0, 0, 6'b100_000, L1, 6);
        add(0, 0, 6'b100_110, L1, 7);
        // Row 42: second collision
        add(0, 1, 6'b010_000, L0, 7);
        for (int i = 0; i < 6; i++) add(0, 0, 6'b010_000, L0, 7);
`ifdef FREE_PLAY_EN
        add(0, 0, 6'b100_000, 2, 7);
        add(0, 0, 6'b100_000, 2, 7);
        add(0, 0, 6'b100_010, 2, 7);
        add(0, 0, 6'b100_000, 2, 7);
        add(0, 0, 6'b100_110, 2, 8);
`else
        add(0, 0, 6'b001_000, 0, 7);
        add(0, 0, 6'b001_000, 0, 7);
        add(0, 0, 6'b001_000, 0, 7);
        add(1, 0, 6'b100_000, 2, 0);
        add(0, 0, 6'b100_000, 2, 0);
        add(1, 0, 6'b100_010, 2, 0);
        add(0, 0, 6'b100_000, 2, 0);
        add(0, 0, 6'b100_110, 2, 1);
`endif

        // Reset phase and idle
        #3 reset = 1'b0;
        #4 chk("reset_vals", outs(), {6'b000_000, 2'd2, 16'd0});
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d", i), outs(), {6'b000_000, 2'd2, 16'd0});
        end

        foreach (tbl[i]) begin
            start    = tbl[i].st;
            colision = tbl[i].col;
            @(negedge clk);
            chk($sformatf("row%0d", i + 1), outs(), {tbl[i].f, tbl[i].l, tbl[i].d});
        end
        start    = 1'b0;
        colision = 1'b0;

        // Distance saturation: slow_cnt is 0 here, so no upsig in the next cycle
        force dut.distance = 16'hFFFE;
        @(negedge clk);
        release dut.distance;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!upsig && n < 10);
            chk($sformatf("sat_up%0d", k), {23'd0, upsig}, 24'd1);
            chk($sformatf("sat_dist%0d", k), {8'd0, distance}, 24'h00FFFF);
        end

        // Crash, then asynchronous reset in the middle of it
        colision = 1'b1;
        @(negedge clk);
        colision = 1'b0;
        chk("crash_enter", outs(), {6'b010_000, L1, 16'hFFFF});
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("async_reset", outs(), {6'b000_000, 2'd2, 16'd0});
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("post_reset%0d", i), outs(), {6'b000_000, 2'd2, 16'd0});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
